// File: rtl/mem_copy_dma_if.sv
// ============================================================================
//  Module      : mem_copy_dma_if
//  Description : Memory request/acknowledge bus between a bus initiator
//                (master) and a memory responder (slave).
//                  mem_rd_en_o  read request, held until acknowledged
//                  mem_wr_en_o  write request, held until acknowledged
//                  mem_addr_o   word-aligned byte address of the request
//                  mem_data_o   write data
//                  mem_data_i   read data, valid with mem_ack_i on a read
//                  mem_ack_i    transaction acknowledge
//                The _o/_i suffixes are from the initiator's point of view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_copy_dma_if;
  logic        mem_rd_en_o;
  logic        mem_wr_en_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_ack_i;

  modport master (
    output mem_rd_en_o,
    output mem_wr_en_o,
    output mem_addr_o,
    output mem_data_o,
    input  mem_data_i,
    input  mem_ack_i
  );

  modport slave (
    input  mem_rd_en_o,
    input  mem_wr_en_o,
    input  mem_addr_o,
    input  mem_data_o,
    output mem_data_i,
    output mem_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/mem_copy_dma.sv
// ============================================================================
//  Module      : mem_copy_dma
//  Description : Simple DMA engine copying a block of 32-bit words from a
//                source range to a destination range, one read followed by
//                one write per word, each request held until acknowledged.
//                A one-cycle gap after every acknowledged request absorbs
//                duplicate acks from responders that re-ack a held request.
//                Unacknowledged requests abort after TIMEOUT_CYCLES cycles.
//  Ports       : clk, rst        clock / synchronous active-high reset
//                start_i         begin a transfer (only looked at when idle)
//                src_addr_i      source byte address (bits [1:0] ignored)
//                dst_addr_i      destination byte address (bits [1:0] ignored)
//                len_i           word count
//                busy_o          transfer in progress
//                done_o          one-cycle pulse at end (normal or aborted)
//                error_o         sticky timeout flag
//                words_done_o    words fully written in current/last transfer
//                bus             memory initiator port (master modport)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_copy_dma #(
  parameter int LEN_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 start_i,
  input  wire logic [31:0]          src_addr_i,
  input  wire logic [31:0]          dst_addr_i,
  input  wire logic [LEN_WIDTH-1:0] len_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic [LEN_WIDTH-1:0]      words_done_o,
  mem_copy_dma_if.master            bus
);

  localparam int                c_TO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_REQ = 3'd1,
    S_RD_GAP = 3'd2,
    S_WR_REQ = 3'd3,
    S_WR_GAP = 3'd4
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [31:0]           r_src,     w_src_nxt;
  logic [31:0]           r_dst,     w_dst_nxt;
  logic [LEN_WIDTH-1:0]  r_len,     w_len_nxt;
  logic [LEN_WIDTH-1:0]  r_words,   w_words_nxt;
  logic [31:0]           r_data,    w_data_nxt;
  logic [c_TO_W-1:0]     r_to_cnt,  w_to_nxt;
  logic                  r_busy,    w_busy_nxt;
  logic                  r_done,    w_done_nxt;
  logic                  r_error,   w_error_nxt;
  logic                  r_rd_en,   w_rd_nxt;
  logic                  r_wr_en,   w_wr_nxt;
  logic [31:0]           r_addr,    w_addr_nxt;

  logic [31:0]           w_src_al;
  logic [31:0]           w_dst_al;
  logic                  w_to_expired;
  logic                  w_unused_lsbs;

  assign w_src_al      = {src_addr_i[31:2], 2'b00};
  assign w_dst_al      = {dst_addr_i[31:2], 2'b00};
  assign w_unused_lsbs = ^{src_addr_i[1:0], dst_addr_i[1:0]};
  // Counter starts at 0 in the first request cycle, so reaching the last
  // value means the request has been held for TIMEOUT_CYCLES cycles.
  assign w_to_expired  = (r_to_cnt == c_TO_LAST);

  // Next-state and next-output logic. Every output is a register, so the
  // values below are what the outputs will show in the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_src_nxt   = r_src;
    w_dst_nxt   = r_dst;
    w_len_nxt   = r_len;
    w_words_nxt = r_words;
    w_data_nxt  = r_data;
    w_to_nxt    = r_to_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_error_nxt = r_error;
    w_rd_nxt    = 1'b0;
    w_wr_nxt    = 1'b0;
    w_addr_nxt  = '0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_src_nxt   = w_src_al;
          w_dst_nxt   = w_dst_al;
          w_len_nxt   = len_i;
          w_words_nxt = '0;
          w_error_nxt = 1'b0;
          if (len_i == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_state_nxt = S_RD_REQ;
            w_busy_nxt  = 1'b1;
            w_rd_nxt    = 1'b1;
            w_addr_nxt  = w_src_al;
            w_to_nxt    = '0;
          end
        end
      end

      S_RD_REQ: begin
        if (bus.mem_ack_i) begin
          w_data_nxt  = bus.mem_data_i;
          w_state_nxt = S_RD_GAP;
        end else if (w_to_expired) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_error_nxt = 1'b1;
        end else begin
          w_to_nxt   = r_to_cnt + c_TO_W'(1);
          w_rd_nxt   = 1'b1;
          w_addr_nxt = r_src;
        end
      end

      S_RD_GAP: begin
        w_state_nxt = S_WR_REQ;
        w_wr_nxt    = 1'b1;
        w_addr_nxt  = r_dst;
        w_to_nxt    = '0;
      end

      S_WR_REQ: begin
        if (bus.mem_ack_i) begin
          w_src_nxt   = r_src + 32'd4;
          w_dst_nxt   = r_dst + 32'd4;
          w_words_nxt = r_words + LEN_WIDTH'(1);
          w_state_nxt = S_WR_GAP;
        end else if (w_to_expired) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_error_nxt = 1'b1;
        end else begin
          w_to_nxt   = r_to_cnt + c_TO_W'(1);
          w_wr_nxt   = 1'b1;
          w_addr_nxt = r_dst;
        end
      end

      S_WR_GAP: begin
        if (r_words == r_len) begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_RD_REQ;
          w_rd_nxt    = 1'b1;
          w_addr_nxt  = r_src;
          w_to_nxt    = '0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_src    <= '0;
      r_dst    <= '0;
      r_len    <= '0;
      r_words  <= '0;
      r_data   <= '0;
      r_to_cnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_wr_en  <= 1'b0;
      r_addr   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_src    <= w_src_nxt;
      r_dst    <= w_dst_nxt;
      r_len    <= w_len_nxt;
      r_words  <= w_words_nxt;
      r_data   <= w_data_nxt;
      r_to_cnt <= w_to_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_error  <= w_error_nxt;
      r_rd_en  <= w_rd_nxt;
      r_wr_en  <= w_wr_nxt;
      r_addr   <= w_addr_nxt;
    end
  end

  assign busy_o          = r_busy;
  assign done_o          = r_done;
  assign error_o         = r_error;
  assign words_done_o    = r_words;
  assign bus.mem_rd_en_o = r_rd_en;
  assign bus.mem_wr_en_o = r_wr_en;
  assign bus.mem_addr_o  = r_addr;
  // The captured read word is presented directly as write data.
  assign bus.mem_data_o  = r_data;

endmodule

`default_nettype wire

// File: tb/tb_mem_copy_dma.sv
// ============================================================================
//  Module      : tb_mem_copy_dma
//  Description : Self-checking bench for mem_copy_dma. A behavioural memory
//                responder with programmable ack latency serves the bus; a
//                word-by-word copy model predicts the request sequence, the
//                completion cycle and the final memory image.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_copy_dma;

  localparam int LW = 16;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_i = 1'b0;
  logic [31:0]   src_addr_i = '0;
  logic [31:0]   dst_addr_i = '0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o, error_o;
  logic [LW-1:0] words_done_o;

  mem_copy_dma_if bus ();

  mem_copy_dma #(.LEN_WIDTH(LW), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .src_addr_i   (src_addr_i),
    .dst_addr_i   (dst_addr_i),
    .len_i        (len_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .error_o      (error_o),
    .words_done_o (words_done_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_rd[$];
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int resp_lat = 0;
  bit rd_ok = 1'b1;
  bit wr_ok = 1'b1;
  int wait_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  task automatic put(input logic [31:0] a, input logic [31:0] v);
    mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Responder: acks resp_lat+1 cycles after a request appears and keeps
  // re-acking for as long as the request stays visible.
  always @(posedge clk) begin
    if (bus.mem_rd_en_o || bus.mem_wr_en_o) begin
      if (wait_cnt >= resp_lat &&
          ((bus.mem_rd_en_o && rd_ok) || (bus.mem_wr_en_o && wr_ok))) begin
        bus.mem_ack_i <= 1'b1;
        if (bus.mem_rd_en_o) bus.mem_data_i <= mem_rd(bus.mem_addr_o);
        if (bus.mem_wr_en_o) mem[bus.mem_addr_o] = bus.mem_data_o;
      end else begin
        bus.mem_ack_i <= 1'b0;
      end
      wait_cnt <= wait_cnt + 1;
    end else begin
      bus.mem_ack_i <= 1'b0;
      wait_cnt <= 0;
    end
  end

  // Request monitor: each new request must match the next predicted one.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_rd_en_o && !prev_rd) begin
        check_eq("rd_excl", 32'(bus.mem_wr_en_o), 32'd0);
        check_eq("rd_pending", 32'(exp_rd.size() > 0), 32'd1);
        if (exp_rd.size() > 0) check_eq("rd_addr", bus.mem_addr_o, exp_rd.pop_front());
      end
      if (bus.mem_wr_en_o && !prev_wr) begin
        check_eq("wr_excl", 32'(bus.mem_rd_en_o), 32'd0);
        check_eq("wr_pending", 32'(exp_wa.size() > 0), 32'd1);
        if (exp_wa.size() > 0) begin
          check_eq("wr_addr", bus.mem_addr_o, exp_wa.pop_front());
          check_eq("wr_data", bus.mem_data_o, exp_wd.pop_front());
        end
      end
    end
    prev_rd <= bus.mem_rd_en_o;
    prev_wr <= bus.mem_wr_en_o;
  end

  // Plans the copy word by word, starts it, and checks completion.
  // Called and returns at a negedge.
  task automatic do_copy(input logic [31:0] src, input logic [31:0] dst,
                         input int len, input int lat, input bit poke);
    logic [31:0] s, d, w;
    int cyc;
    resp_lat = lat;
    rd_ok = 1'b1;
    wr_ok = 1'b1;
    s = {src[31:2], 2'b00};
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      w = ref_rd(s);
      exp_rd.push_back(s);
      exp_wa.push_back(d);
      exp_wd.push_back(w);
      ref_mem[d] = w;
      s += 32'd4;
      d += 32'd4;
    end
    start_i = 1'b1; src_addr_i = src; dst_addr_i = dst; len_i = LW'(len);
    @(posedge clk);
    #1 start_i = 1'b0; src_addr_i = $urandom; dst_addr_i = $urandom; len_i = LW'($urandom);
    cyc = 0;
    @(negedge clk);
    check_eq("busy", 32'(busy_o), 32'(len != 0));
    check_eq("err_clr", 32'(error_o), 32'd0);
    while (!done_o && cyc < 2000) begin
      if (poke && cyc == 4) begin
        start_i = 1'b1; src_addr_i = 32'h0000_9000; dst_addr_i = 32'h0000_A000; len_i = LW'(7);
      end
      @(posedge clk);
      cyc++;
      #1 start_i = 1'b0;
      @(negedge clk);
    end
    check_eq("done_seen", 32'(done_o), 32'd1);
    check_eq("done_cyc", cyc, len * (2 * lat + 6));
    check_eq("words", 32'(words_done_o), len);
    check_eq("error", 32'(error_o), 32'd0);
    check_eq("busy_end", 32'(busy_o), 32'd0);
    @(negedge clk);
    check_eq("done_pulse", 32'(done_o), 32'd0);
    check_eq("rd_left", exp_rd.size(), 32'd0);
    check_eq("wr_left", exp_wa.size(), 32'd0);
    d = {dst[31:2], 2'b00};
    for (int i = 0; i < len; i++) begin
      check_eq("mem", mem_rd(d), ref_rd(d));
      d += 32'd4;
    end
  endtask

  initial begin
    int cyc, hold;
    logic [31:0] rs, rd, w;
    int rl;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rd", 32'(bus.mem_rd_en_o), 32'd0);
    check_eq("rst_wr", 32'(bus.mem_wr_en_o), 32'd0);
    check_eq("rst_addr", bus.mem_addr_o, 32'd0);
    check_eq("rst_data", bus.mem_data_o, 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_done", 32'(done_o), 32'd0);
    check_eq("rst_err", 32'(error_o), 32'd0);
    check_eq("rst_words", 32'(words_done_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 4-word copy with one-cycle-latency responder.
    for (int i = 0; i < 4; i++) put(32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
    do_copy(32'h100, 32'h200, 4, 0, 1'b0);

    // Zero-length transfer.
    do_copy(32'h100, 32'h280, 0, 0, 1'b0);

    // Source wraps past the top of the address space; misaligned destination.
    put(32'hFFFF_FFF8, 32'h1111_0001);
    put(32'hFFFF_FFFC, 32'h1111_0002);
    put(32'h0000_0000, 32'h1111_0003);
    do_copy(32'hFFFF_FFF8, 32'h303, 3, 0, 1'b0);

    // Start pulsed while busy must be ignored.
    for (int i = 0; i < 3; i++) put(32'h700 + 32'(4 * i), $urandom);
    do_copy(32'h700, 32'h800, 3, 1, 1'b1);

    // Write timeout: writes never acknowledged.
    put(32'h400, 32'hCAFE_0400);
    resp_lat = 0; rd_ok = 1'b1; wr_ok = 1'b0;
    exp_rd.push_back(32'h400);
    exp_wa.push_back(32'h500);
    exp_wd.push_back(32'hCAFE_0400);
    start_i = 1'b1; src_addr_i = 32'h400; dst_addr_i = 32'h500; len_i = LW'(3);
    @(posedge clk);
    #1 start_i = 1'b0;
    cyc = 0; hold = 0;
    @(negedge clk);
    while (!done_o && cyc < 200) begin
      if (bus.mem_wr_en_o) hold++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_eq("to_done", 32'(done_o), 32'd1);
    check_eq("to_cyc", cyc, 32'd11);
    check_eq("to_hold", hold, TO);
    check_eq("to_err", 32'(error_o), 32'd1);
    check_eq("to_words", 32'(words_done_o), 32'd0);
    check_eq("to_busy", 32'(busy_o), 32'd0);
    check_eq("to_wr", 32'(bus.mem_wr_en_o), 32'd0);
    repeat (3) @(negedge clk);
    check_eq("to_sticky", 32'(error_o), 32'd1);
    check_eq("to_nowrite", mem_rd(32'h500), 32'd0);
    for (int i = 0; i < 2; i++) put(32'h480 + 32'(4 * i), $urandom);
    do_copy(32'h480, 32'h580, 2, 0, 1'b0);

    // Reset during the second word's write request.
    for (int i = 0; i < 4; i++) put(32'h600 + 32'(4 * i), 32'hBB00 + 32'(i));
    resp_lat = 0; rd_ok = 1'b1; wr_ok = 1'b1;
    for (int i = 0; i < 2; i++) begin
      exp_rd.push_back(32'h600 + 32'(4 * i));
      exp_wa.push_back(32'h680 + 32'(4 * i));
      exp_wd.push_back(32'hBB00 + 32'(i));
      ref_mem[32'h680 + 32'(4 * i)] = 32'hBB00 + 32'(i);
    end
    start_i = 1'b1; src_addr_i = 32'h600; dst_addr_i = 32'h680; len_i = LW'(4);
    @(posedge clk);
    #1 start_i = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!(bus.mem_wr_en_o && words_done_o == LW'(1)) && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    check_eq("rst_reach", 32'(bus.mem_wr_en_o && words_done_o == LW'(1)), 32'd1);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("mrst_rd", 32'(bus.mem_rd_en_o), 32'd0);
      check_eq("mrst_wr", 32'(bus.mem_wr_en_o), 32'd0);
      check_eq("mrst_busy", 32'(busy_o), 32'd0);
      check_eq("mrst_done", 32'(done_o), 32'd0);
      check_eq("mrst_words", 32'(words_done_o), 32'd0);
      check_eq("mrst_addr", bus.mem_addr_o, 32'd0);
      check_eq("mrst_data", bus.mem_data_o, 32'd0);
    end
    check_eq("mrst_q", exp_rd.size() + exp_wa.size(), 32'd0);
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    do_copy(32'h600, 32'h6C0, 4, 0, 1'b0);

    // Randomized copies with random responder latency.
    for (int t = 0; t < 8; t++) begin
      rl = $urandom_range(1, 6);
      rs = 32'h1000 + 32'($urandom_range(0, 1023));
      rd = 32'h2000 + 32'($urandom_range(0, 1023));
      w = {rs[31:2], 2'b00};
      for (int i = 0; i < rl; i++) put(w + 32'(4 * i), $urandom);
      do_copy(rs, rd, rl, $urandom_range(0, 3), 1'(t % 2));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
